row_load_ctrl: RTL and testbench

Sequencer that fills one of the three 1536×32 row buffers from the full-IFM buffer on request from the main controller. Each request copies one spatial row (all columns × tiled channels) and zero-fills out-of-range (padding) rows. It owns the above/cur/below pointer rotation and drives the IFM-buffer read port and the row-buffer write ports. It sits inside the buffer manager, between the IFM dpram and the row-buffer drams feeding pe_engine.

---
 rtl/row_load_ctrl.sv | 159 +++++++++++++++
 tb/tb_row_load_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/row_load_ctrl.sv
// Row-buffer load sequencer: copies one spatial row from the IFM buffer into the
// row buffer currently at ptr_below, zero-filling padding rows, and owns pointer rotation.
module row_load_ctrl #(
   parameter int unsigned W_SIZE    = 10,
   parameter int unsigned W_CHANNEL = 10,
   parameter int unsigned IFM_DW    = 32,
   parameter int unsigned IFM_AW    = 16,
   parameter int unsigned ROW_DEPTH = 1536,
   parameter int unsigned RB_AW     = 11
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic [W_SIZE-1:0]    q_width,
   input  logic [W_SIZE-1:0]    q_height,
   input  logic [W_CHANNEL-1:0] q_channel,
   input  logic                 q_layer_start,
   input  logic                 m_req_load,
   input  logic [W_SIZE-1:0]    m_req_row,
   input  logic                 m_rotate,
   output logic [IFM_AW-1:0]    ifm_rd_addr,
   input  logic [IFM_DW-1:0]    ifm_rd_data,
   output logic [2:0]           rb_we,
   output logic [RB_AW-1:0]     rb_addr,
   output logic [IFM_DW-1:0]    rb_din,
   output logic [1:0]           ptr_above,
   output logic [1:0]           ptr_cur,
   output logic [1:0]           ptr_below,
   output logic                 o_busy,
   output logic                 o_req_done,
   output logic                 o_req_err
);
   localparam int unsigned NW = W_SIZE + W_CHANNEL;
   localparam int unsigned PW = W_SIZE + NW;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t            state, state_d;
   logic [1:0]        tgt, tgt_d;
   logic              pad, pad_d;
   logic [IFM_AW-1:0] base, base_d;
   logic [RB_AW-1:0]  cnt, cnt_d;
   logic [RB_AW-1:0]  last, last_d;
   logic [IFM_AW-1:0] ifm_rd_addr_d;
   logic [2:0]        rb_we_d;
   logic [RB_AW-1:0]  rb_addr_d;
   logic [1:0]        ptr_above_d, ptr_cur_d, ptr_below_d;
   logic              busy_d, done_d, err_d;

   logic [NW-1:0]     n_full;
   logic [PW-1:0]     base_full;

   assign n_full    = NW'(q_width) * NW'(q_channel);
   assign base_full = PW'(m_req_row) * PW'(n_full);

   // The dpram's own output register is the write-stage data register, so the
   // data passes straight through, qualified by the registered write enable.
   assign rb_din = (rb_we != 3'b000 && !pad) ? ifm_rd_data : '0;

   // Next-state and next-output logic
   always_comb begin
      state_d       = state;
      tgt_d         = tgt;
      pad_d         = pad;
      base_d        = base;
      cnt_d         = cnt;
      last_d        = last;
      ifm_rd_addr_d = ifm_rd_addr;
      rb_we_d       = 3'b000;
      rb_addr_d     = rb_addr;
      err_d         = 1'b0;
      ptr_above_d   = ptr_above;
      ptr_cur_d     = ptr_cur;
      ptr_below_d   = ptr_below;

      if (q_layer_start) begin
         ptr_above_d = 2'd0;
         ptr_cur_d   = 2'd1;
         ptr_below_d = 2'd2;
      end else if (m_rotate) begin
         ptr_above_d = ptr_cur;
         ptr_cur_d   = ptr_below;
         ptr_below_d = ptr_above;
      end

      case (state)
         IDLE: begin
            if (m_req_load) begin
               if (n_full > NW'(ROW_DEPTH)) begin
                  err_d = 1'b1;
               end else begin
                  tgt_d         = ptr_below;
                  pad_d         = (m_req_row >= q_height);
                  base_d        = IFM_AW'(base_full);
                  last_d        = RB_AW'(n_full - NW'(1));
                  cnt_d         = '0;
                  ifm_rd_addr_d = IFM_AW'(base_full);
                  // An empty row still spends a DRAIN cycle so done timing is uniform
                  state_d       = (n_full == '0) ? DRAIN : RUN;
               end
            end
         end
         RUN: begin
            rb_we_d   = 3'b001 << tgt;
            rb_addr_d = cnt;
            if (cnt == last) begin
               state_d = DRAIN;
            end else begin
               cnt_d         = cnt + RB_AW'(1);
               ifm_rd_addr_d = base + IFM_AW'(cnt) + IFM_AW'(1);
            end
         end
         DRAIN:   state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      if (m_req_load && state != IDLE) err_d = 1'b1;

      busy_d = (state_d != IDLE);
      done_d = (state_d == DONE);
   end

   // State and output registers
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state       <= IDLE;
         tgt         <= 2'd0;
         pad         <= 1'b0;
         base        <= '0;
         cnt         <= '0;
         last        <= '0;
         ifm_rd_addr <= '0;
         rb_we       <= 3'b000;
         rb_addr     <= '0;
         ptr_above   <= 2'd0;
         ptr_cur     <= 2'd1;
         ptr_below   <= 2'd2;
         o_busy      <= 1'b0;
         o_req_done  <= 1'b0;
         o_req_err   <= 1'b0;
      end else begin
         state       <= state_d;
         tgt         <= tgt_d;
         pad         <= pad_d;
         base        <= base_d;
         cnt         <= cnt_d;
         last        <= last_d;
         ifm_rd_addr <= ifm_rd_addr_d;
         rb_we       <= rb_we_d;
         rb_addr     <= rb_addr_d;
         ptr_above   <= ptr_above_d;
         ptr_cur     <= ptr_cur_d;
         ptr_below   <= ptr_below_d;
         o_busy      <= busy_d;
         o_req_done  <= done_d;
         o_req_err   <= err_d;
      end
   end
endmodule

// File: tb/tb_row_load_ctrl.sv
// Scoreboard bench for row_load_ctrl: a request-level model queues expected reads,
// writes, done and error events by cycle; a negedge monitor checks them.
module tb_row_load_ctrl;
   logic        clk = 1'b0;
   logic        rstn;
   logic [9:0]  q_width, q_height, q_channel;
   logic        q_layer_start, m_req_load, m_rotate;
   logic [9:0]  m_req_row;
   logic [15:0] ifm_rd_addr;
   logic [31:0] ifm_rd_data;
   logic [2:0]  rb_we;
   logic [10:0] rb_addr;
   logic [31:0] rb_din;
   logic [1:0]  ptr_above, ptr_cur, ptr_below;
   logic        o_busy, o_req_done, o_req_err;

   row_load_ctrl dut (
      .clk(clk), .rstn(rstn), .q_width(q_width), .q_height(q_height), .q_channel(q_channel),
      .q_layer_start(q_layer_start), .m_req_load(m_req_load), .m_req_row(m_req_row),
      .m_rotate(m_rotate), .ifm_rd_addr(ifm_rd_addr), .ifm_rd_data(ifm_rd_data),
      .rb_we(rb_we), .rb_addr(rb_addr), .rb_din(rb_din), .ptr_above(ptr_above),
      .ptr_cur(ptr_cur), .ptr_below(ptr_below), .o_busy(o_busy), .o_req_done(o_req_done),
      .o_req_err(o_req_err));

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [31:0] mult = 32'd1, salt = 32'd0;
   function automatic logic [31:0] ifm_word(input logic [15:0] a);
      return (32'(a) * mult) ^ salt;
   endfunction

   // IFM dpram port b: one-cycle read latency
   always @(posedge clk) ifm_rd_data <= ifm_word(ifm_rd_addr);

   typedef struct { int cyc; logic [2:0] we; int addr; logic [31:0] din; } wr_t;
   typedef struct { int cyc; int addr; } rd_t;
   wr_t wq[$];
   rd_t rq[$];
   int  dq[$], eq[$];
   int  pa = 0, pc = 1, pb = 2;
   int  busy_start = 0, busy_end = -1;
   int  n_cmp = 0, n_fail = 0;

   task automatic chk(input string nm, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
      end
   endtask

   // Request-level reference: what a request issued during cycle x must produce
   task automatic model_req(input int x, input int row);
      int n, base;
      bit p;
      n = int'(q_width) * int'(q_channel);
      if (x <= busy_end || n > 1536) begin
         eq.push_back(x + 1);
      end else begin
         base = (row * n) & 16'hFFFF;
         p    = (row >= int'(q_height));
         for (int i = 0; i < n; i++) begin
            wr_t w;
            rd_t r;
            r.cyc = x + 1 + i; r.addr = (base + i) & 16'hFFFF;
            w.cyc = x + 2 + i; w.we = 3'(1 << pb); w.addr = i;
            w.din = p ? 32'd0 : ifm_word(16'(r.addr));
            rq.push_back(r);
            wq.push_back(w);
         end
         dq.push_back(x + n + 2);
         busy_start = x + 1;
         busy_end   = x + n + 2;
      end
   endtask

   task automatic step(input bit ld, input int row, input bit rot, input bit ls);
      m_req_load = ld; m_req_row = 10'(row); m_rotate = rot; q_layer_start = ls;
      if (ld) model_req(cyc, row);
      @(posedge clk);
      if (ls) begin pa = 0; pc = 1; pb = 2; end
      else if (rot) begin int t; t = pa; pa = pc; pc = pb; pb = t; end
      #1;
      m_req_load = 1'b0; m_rotate = 1'b0; q_layer_start = 1'b0;
   endtask

   task automatic wait_idle();
      int budget;
      budget = 0;
      while (cyc <= busy_end + 1 && budget < 3000) begin step(0, 0, 0, 0); budget++; end
      if (budget >= 3000) chk("idle_timeout", 1, 0);
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      wq.delete(); rq.delete(); dq.delete(); eq.delete();
      pa = 0; pc = 1; pb = 2; busy_start = 0; busy_end = -1;
      repeat (2) @(posedge clk);
      #1 rstn = 1'b1;
   endtask

   task automatic set_q(input int w, input int c, input int h);
      q_width = 10'(w); q_channel = 10'(c); q_height = 10'(h);
   endtask

   // Monitor: compare DUT outputs against the scoreboard every cycle
   initial begin
      forever begin
         @(negedge clk);
         if (!rstn) begin
            chk("reset_vals", {ifm_rd_addr, rb_we, rb_addr, rb_din, ptr_above, ptr_cur, ptr_below,
                               o_busy, o_req_done, o_req_err},
                {16'd0, 3'd0, 11'd0, 32'd0, 2'd0, 2'd1, 2'd2, 3'b000});
            continue;
         end
         chk("ptrs", {ptr_above, ptr_cur, ptr_below}, {2'(pa), 2'(pc), 2'(pb)});
         chk("busy", o_busy, (cyc >= busy_start && cyc <= busy_end));
         if (rq.size() > 0 && rq[0].cyc <= cyc) begin
            rd_t r;
            r = rq.pop_front();
            chk("rd_cycle", cyc, r.cyc);
            chk("rd_addr", ifm_rd_addr, r.addr);
         end
         if (rb_we != 3'b000) begin
            if (wq.size() == 0) chk("unexpected_write", rb_we, 0);
            else begin
               wr_t w;
               w = wq.pop_front();
               chk("wr_cycle", cyc, w.cyc);
               chk("wr_we", rb_we, w.we);
               chk("wr_addr", rb_addr, w.addr);
               chk("wr_din", rb_din, w.din);
            end
         end else if (wq.size() > 0 && wq[0].cyc <= cyc) begin
            chk("missing_write", cyc, wq[0].cyc + 1000000);
            void'(wq.pop_front());
         end
         if (o_req_done) begin
            if (dq.size() == 0) chk("unexpected_done", 1, 0);
            else chk("done_cycle", cyc, dq.pop_front());
         end else if (dq.size() > 0 && dq[0] <= cyc) chk("missing_done", cyc, dq.pop_front());
         if (o_req_err) begin
            if (eq.size() == 0) chk("unexpected_err", 1, 0);
            else chk("err_cycle", cyc, eq.pop_front());
         end else if (eq.size() > 0 && eq[0] <= cyc) chk("missing_err", cyc, eq.pop_front());
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
      $fatal(1);
   end

   initial begin
      rstn = 1'b0; m_req_load = 1'b0; m_rotate = 1'b0; q_layer_start = 1'b0; m_req_row = '0;
      set_q(4, 2, 4);
      repeat (3) @(posedge clk);
      #1 rstn = 1'b1;
      repeat (2) step(0, 0, 0, 0);

      // Basic row copy and a padding row; IFM word equals its address
      step(1, 1, 0, 0); wait_idle();
      step(1, 4, 0, 0); wait_idle();

      // Rotation: three rotates wrap, rotate mid-load, layer_start beats rotate
      repeat (3) step(0, 0, 1, 0);
      step(1, 2, 0, 0); step(0, 0, 0, 0); step(0, 0, 1, 0); wait_idle();
      step(0, 0, 1, 1); step(0, 0, 0, 0);

      // Busy collision: second request three cycles in
      step(1, 1, 0, 0); step(0, 0, 0, 0); step(0, 0, 0, 0); step(1, 2, 0, 0); wait_idle();

      // Depth limits and empty rows
      mult = 32'h9E3779B1; salt = 32'h5A5A1234;
      set_q(48, 32, 64); step(1, 3, 0, 0); wait_idle();
      set_q(49, 32, 64); step(1, 0, 0, 0); wait_idle();
      set_q(4, 0, 4);    step(1, 1, 0, 0); wait_idle();

      // Randomized traffic
      for (int it = 0; it < 40; it++) begin
         int h;
         wait_idle();
         h = $urandom_range(1, 8);
         if ($urandom_range(0, 9) == 0) set_q($urandom_range(40, 60), 32, h);
         else set_q($urandom_range(1, 10), $urandom_range(0, 6), h);
         mult = $urandom | 32'd1; salt = $urandom;
         for (int k = 0; k < 30; k++)
            step($urandom_range(0, 5) == 0, $urandom_range(0, h + 2),
                 $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0);
      end
      wait_idle();

      // Reset in the middle of a load
      set_q(4, 2, 4);
      step(1, 1, 0, 0);
      repeat (4) step(0, 0, 0, 0);
      do_reset();
      repeat (12) step(0, 0, 0, 0);

      chk("leftover", wq.size() + rq.size() + dq.size() + eq.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
